// File: rtl/fetch_pkg.sv
// Shared fetch-path types: the instruction fetch entry and the NOP filler word.
// Reused by the fetch queue and the IF/ID pipeline register.
package fetch_pkg;

    localparam int          FQ_XLEN   = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_XLEN-1:0] pc4;
        logic [FQ_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// DEPTH x fetch_entry_t storage, one synchronous write port, one asynchronous read port.
// Latency: write visible on read port after the write edge. No backpressure; not reset.
module fetch_queue_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  fetch_entry_t  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output fetch_entry_t  o_rdata
);

    fetch_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between PC/fetch and decode; flush empties it in one cycle.
// Latency: 1 cycle enqueue-to-dequeue, no bypass when empty.
// Backpressure: keep_pc = full (registered state only); enqueue refused while full.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = FQ_XLEN
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     enq_valid,
    input  logic [XLEN-1:0]          enq_pc,
    input  logic [XLEN-1:0]          enq_pc4,
    input  logic [XLEN-1:0]          enq_instr,
    output logic                     keep_pc,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [XLEN-1:0]          deq_pc,
    output logic [XLEN-1:0]          deq_pc4,
    output logic [XLEN-1:0]          deq_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW:0]  r_rd_ptr;
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  w_count;
    logic         w_full;
    logic         w_empty;
    logic         w_enq_fire;
    logic         w_deq_fire;
    fetch_entry_t w_wdata;
    fetch_entry_t w_rdata;

    // Extra wrap bit on each pointer lets the difference span 0..DEPTH.
    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_full     = (w_count == FULL_CNT);
    assign w_empty    = (w_count == '0);
    assign w_enq_fire = enq_valid & ~w_full & ~flush;
    assign w_deq_fire = ~w_empty & deq_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_enq_fire) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign w_wdata.pc    = enq_pc;
    assign w_wdata.pc4   = enq_pc4;
    assign w_wdata.instr = enq_instr;

    fetch_queue_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_enq_fire),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

    // Storage is never reset, so stale data is masked whenever the queue is empty.
    assign deq_valid = ~w_empty;
    assign deq_pc    = w_empty ? '0        : w_rdata.pc;
    assign deq_pc4   = w_empty ? '0        : w_rdata.pc4;
    assign deq_instr = w_empty ? INSTR_NOP : w_rdata.instr;
    assign keep_pc   = w_full;
    assign count     = w_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a scoreboard queue of expected head PCs.
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        enq_valid;
    logic [31:0] enq_pc;
    logic [31:0] enq_pc4;
    logic [31:0] enq_instr;
    logic        keep_pc;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_pc;
    logic [31:0] deq_pc4;
    logic [31:0] deq_instr;
    logic [2:0]  count;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sb [$];
    logic [31:0] nxt_pc;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_pc    (enq_pc),
        .enq_pc4   (enq_pc4),
        .enq_instr (enq_instr),
        .keep_pc   (keep_pc),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_pc    (deq_pc),
        .deq_pc4   (deq_pc4),
        .deq_instr (deq_instr),
        .count     (count)
    );

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return {pc[24:0], 7'h33} ^ 32'h5A00_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check outputs against the model, then clock one edge and update the model.
    task automatic step(input logic en, input logic [31:0] pc, input logic dr, input logic fl);
        logic acc;
        logic pop;
        enq_valid = en;
        enq_pc    = pc;
        enq_pc4   = pc + 32'd4;
        enq_instr = mk_instr(pc);
        deq_ready = dr;
        flush     = fl;
        #1;
        chk("count",     {29'd0, count},        sb.size());
        chk("deq_valid", {31'd0, deq_valid},    {31'd0, sb.size() != 0});
        chk("keep_pc",   {31'd0, keep_pc},      {31'd0, sb.size() == DEPTH});
        if (sb.size() != 0) begin
            chk("head_pc",    deq_pc,    sb[0]);
            chk("head_pc4",   deq_pc4,   sb[0] + 32'd4);
            chk("head_instr", deq_instr, mk_instr(sb[0]));
        end else begin
            chk("empty_pc",    deq_pc,    32'd0);
            chk("empty_instr", deq_instr, NOP);
        end
        acc = en && (sb.size() < DEPTH) && !fl;
        pop = (sb.size() != 0) && dr && !fl;
        @(posedge clk);
        if (fl) begin
            sb.delete();
        end else begin
            if (pop) void'(sb.pop_front());
            if (acc) sb.push_back(pc);
        end
        if (acc && pc == nxt_pc) nxt_pc = nxt_pc + 32'd4;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
        enq_pc = '0; enq_pc4 = '0; enq_instr = '0;
        nxt_pc = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Idle after reset.
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        // Fill to full; fifth enqueue refused.
        repeat (4) step(1'b1, nxt_pc, 1'b0, 1'b0);
        step(1'b1, nxt_pc, 1'b0, 1'b0);
        chk("refused_pc10", {31'd0, sb.size() == DEPTH && nxt_pc == 32'h10}, 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        // Streaming from full for 8 cycles; pointers wrap.
        repeat (8) step(1'b1, nxt_pc, 1'b1, 1'b0);

        // Drain to 2, then simultaneous enq/deq.
        while (sb.size() > 2) step(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (4) step(1'b1, nxt_pc, 1'b1, 1'b0);

        // Three held, flush with a concurrent enqueue of 0x40.
        step(1'b1, nxt_pc, 1'b0, 1'b0);
        chk("pre_flush_cnt", {29'd0, count}, 32'd3);
        step(1'b1, 32'h40, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h80, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle with three entries held.
        repeat (3) step(1'b1, nxt_pc, 1'b0, 1'b0);
        enq_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_count",     {29'd0, count},     32'd0);
        chk("rst_deq_valid", {31'd0, deq_valid}, 32'd0);
        chk("rst_keep_pc",   {31'd0, keep_pc},   32'd0);
        chk("rst_deq_pc",    deq_pc,             32'd0);
        chk("rst_deq_pc4",   deq_pc4,            32'd0);
        chk("rst_deq_instr", deq_instr,          NOP);
        sb.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Operation resumes after reset.
        step(1'b1, 32'h200, 1'b0, 1'b0);
        step(1'b1, 32'h204, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
